// File: rtl/rf_multiport.sv
// Two-read/one-write register file with byte-enabled writes, write-first bypass,
// registered reads, a sequenced soft-clear sweep and a registered LED byte view.
module rf_multiport #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int ZERO_REG = 1,
    localparam int NB      = DATA_W / 8,
    localparam int LSEL_W  = (NB > 1) ? $clog2(NB) : 1
) (
    input  logic              RF_clk,
    input  logic              RF_Reset,
    input  logic              RF_We,
    input  logic [ADDR_W-1:0] RF_W_Addr,
    input  logic [DATA_W-1:0] RF_W_Data,
    input  logic [NB-1:0]     RF_W_Be,
    input  logic [ADDR_W-1:0] RF_R_Addr_A,
    input  logic [ADDR_W-1:0] RF_R_Addr_B,
    output logic [DATA_W-1:0] RF_R_Data_A,
    output logic [DATA_W-1:0] RF_R_Data_B,
    input  logic              RF_Clr,
    output logic              RF_Busy,
    input  logic              RF_Port_Sel,
    input  logic [LSEL_W-1:0] RF_LED_Sel,
    output logic [7:0]        RF_LED
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [ADDR_W:0] LAST_IDX = (ADDR_W+1)'(DEPTH - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_t;

    state_t              state, state_next;
    logic [ADDR_W:0]     clr_cnt, clr_cnt_next;
    logic [DATA_W-1:0]   mem [DEPTH];
    logic                idle;
    logic                wr_ok;
    logic [DATA_W-1:0]   wr_merged;
    logic [DATA_W-1:0]   rd_a_next, rd_b_next;
    logic [DATA_W-1:0]   led_src;
    logic [7:0]          led_next;

    assign idle    = (state == IDLE);
    assign RF_Busy = (state == CLEAR);
    // Writes to the hardwired-zero register are dropped here so neither the array nor the bypass sees them.
    assign wr_ok   = RF_We && idle && !((ZERO_REG != 0) && (RF_W_Addr == '0));

    always_comb begin
        wr_merged = mem[RF_W_Addr];
        for (int b = 0; b < NB; b++) begin
            if (RF_W_Be[b]) begin
                wr_merged[b*8 +: 8] = RF_W_Data[b*8 +: 8];
            end
        end
    end

    always_comb begin
        rd_a_next = mem[RF_R_Addr_A];
        rd_b_next = mem[RF_R_Addr_B];
        if (wr_ok && (RF_R_Addr_A == RF_W_Addr)) rd_a_next = wr_merged;
        if (wr_ok && (RF_R_Addr_B == RF_W_Addr)) rd_b_next = wr_merged;
        if ((ZERO_REG != 0) && (RF_R_Addr_A == '0)) rd_a_next = '0;
        if ((ZERO_REG != 0) && (RF_R_Addr_B == '0)) rd_b_next = '0;
    end

    always_comb begin
        state_next   = state;
        clr_cnt_next = clr_cnt;
        case (state)
            IDLE: begin
                if (RF_Clr) begin
                    state_next   = CLEAR;
                    clr_cnt_next = '0;
                end
            end
            CLEAR: begin
                if (clr_cnt == LAST_IDX) begin
                    state_next   = IDLE;
                    clr_cnt_next = '0;
                end else begin
                    clr_cnt_next = clr_cnt + 1'b1;
                end
            end
            default: begin
                state_next   = IDLE;
                clr_cnt_next = '0;
            end
        endcase
    end

    always_ff @(posedge RF_clk or posedge RF_Reset) begin
        if (RF_Reset) begin
            state   <= IDLE;
            clr_cnt <= '0;
        end else begin
            state   <= state_next;
            clr_cnt <= clr_cnt_next;
        end
    end

    // The sweep has priority; writes cannot reach the array while it runs.
    always_ff @(posedge RF_clk or posedge RF_Reset) begin
        if (RF_Reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (state == CLEAR) begin
            mem[clr_cnt[ADDR_W-1:0]] <= '0;
        end else if (wr_ok) begin
            mem[RF_W_Addr] <= wr_merged;
        end
    end

    always_comb begin
        led_src  = RF_Port_Sel ? RF_R_Data_B : RF_R_Data_A;
        led_next = '0;
        for (int i = 0; i < NB; i++) begin
            if (RF_LED_Sel == LSEL_W'(i)) led_next = led_src[i*8 +: 8];
        end
    end

    always_ff @(posedge RF_clk or posedge RF_Reset) begin
        if (RF_Reset) begin
            RF_R_Data_A <= '0;
            RF_R_Data_B <= '0;
            RF_LED      <= '0;
        end else begin
            RF_R_Data_A <= rd_a_next;
            RF_R_Data_B <= rd_b_next;
            RF_LED      <= led_next;
        end
    end

endmodule

// File: tb/tb_rf_multiport.sv
// Self-checking bench for rf_multiport: vector table, soft-clear and async-reset
// sequences, randomized traffic against an array model, plus narrow-width instances.
module tb_rf_multiport;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // ---------------- main instance (32-bit, 32 regs, zero reg) ----------------
    logic        we, clr, psel;
    logic [4:0]  wa, ra, rb;
    logic [31:0] wd;
    logic [3:0]  be;
    logic [1:0]  lsel;
    logic [31:0] rd_a, rd_b;
    logic        busy;
    logic [7:0]  led;

    rf_multiport #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(1)) u_dut (
        .RF_clk(clk), .RF_Reset(rst), .RF_We(we), .RF_W_Addr(wa), .RF_W_Data(wd),
        .RF_W_Be(be), .RF_R_Addr_A(ra), .RF_R_Addr_B(rb), .RF_R_Data_A(rd_a),
        .RF_R_Data_B(rd_b), .RF_Clr(clr), .RF_Busy(busy), .RF_Port_Sel(psel),
        .RF_LED_Sel(lsel), .RF_LED(led)
    );

    // ---------------- small instance (16-bit, 8 regs, no zero reg) ----------------
    logic        s_we, s_clr, s_psel, s_busy;
    logic [2:0]  s_wa, s_ra, s_rb;
    logic [15:0] s_wd, s_rd_a, s_rd_b;
    logic [1:0]  s_be;
    logic [0:0]  s_lsel;
    logic [7:0]  s_led;

    rf_multiport #(.DATA_W(16), .ADDR_W(3), .ZERO_REG(0)) u_small (
        .RF_clk(clk), .RF_Reset(rst), .RF_We(s_we), .RF_W_Addr(s_wa), .RF_W_Data(s_wd),
        .RF_W_Be(s_be), .RF_R_Addr_A(s_ra), .RF_R_Addr_B(s_rb), .RF_R_Data_A(s_rd_a),
        .RF_R_Data_B(s_rd_b), .RF_Clr(s_clr), .RF_Busy(s_busy), .RF_Port_Sel(s_psel),
        .RF_LED_Sel(s_lsel), .RF_LED(s_led)
    );

    // ---------------- odd-width instance (24-bit: LED select can go out of range) ----------------
    logic        o_we, o_clr, o_psel, o_busy;
    logic [1:0]  o_wa, o_ra, o_rb, o_lsel;
    logic [23:0] o_wd, o_rd_a, o_rd_b;
    logic [2:0]  o_be;
    logic [7:0]  o_led;

    rf_multiport #(.DATA_W(24), .ADDR_W(2), .ZERO_REG(0)) u_odd (
        .RF_clk(clk), .RF_Reset(rst), .RF_We(o_we), .RF_W_Addr(o_wa), .RF_W_Data(o_wd),
        .RF_W_Be(o_be), .RF_R_Addr_A(o_ra), .RF_R_Addr_B(o_rb), .RF_R_Data_A(o_rd_a),
        .RF_R_Data_B(o_rd_b), .RF_Clr(o_clr), .RF_Busy(o_busy), .RF_Port_Sel(o_psel),
        .RF_LED_Sel(o_lsel), .RF_LED(o_led)
    );

    // ---------------- scoreboard counters ----------------
    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_idle();
        we = 0; wa = 0; wd = 0; be = 0; ra = 0; rb = 0; clr = 0; psel = 0; lsel = 0;
        s_we = 0; s_wa = 0; s_wd = 0; s_be = 0; s_ra = 0; s_rb = 0; s_clr = 0; s_psel = 0; s_lsel = 0;
        o_we = 0; o_wa = 0; o_wd = 0; o_be = 0; o_ra = 0; o_rb = 0; o_clr = 0; o_psel = 0; o_lsel = 0;
    endtask

    task automatic do_reset();
        drive_idle();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic        we;
        logic [4:0]  wa;
        logic [31:0] wd;
        logic [3:0]  be;
        logic [4:0]  ra;
        logic [4:0]  rb;
        logic        psel;
        logic [1:0]  lsel;
        logic [31:0] ea;
        logic [31:0] eb;
        logic [7:0]  eled;
    } vec_t;

    vec_t vecs[8];

    // ---------------- behavioural model ----------------
    logic [31:0] m_mem [32];
    int          m_left;
    logic [31:0] m_pa, m_pb;

    task automatic model_reset();
        for (int i = 0; i < 32; i++) m_mem[i] = '0;
        m_left = 0;
        m_pa = '0;
        m_pb = '0;
    endtask

    task automatic model_cycle();
        logic        wr;
        logic [31:0] merged, ea, eb, src;
        logic [7:0]  el;
        wr = we && (m_left == 0) && (wa != 0);
        merged = m_mem[wa];
        for (int b = 0; b < 4; b++) if (be[b]) merged[b*8 +: 8] = wd[b*8 +: 8];
        ea = (ra == 0) ? 32'h0 : ((wr && ra == wa) ? merged : m_mem[ra]);
        eb = (rb == 0) ? 32'h0 : ((wr && rb == wa) ? merged : m_mem[rb]);
        src = psel ? m_pb : m_pa;
        el = src[8*lsel +: 8];
        if (m_left > 0) begin
            m_mem[32 - m_left] = '0;
            m_left--;
        end else begin
            if (wr) m_mem[wa] = merged;
            if (clr) m_left = 32;
        end
        tick();
        check("rand_rd_a", rd_a, ea);
        check("rand_rd_b", rd_b, eb);
        check("rand_led", 32'(led), 32'(el));
        check("rand_busy", 32'(busy), 32'(m_left > 0));
        m_pa = ea;
        m_pb = eb;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int cyc;

        vecs[0] = '{1'b1, 5'd5, 32'hDEADBEEF, 4'hF, 5'd5, 5'd0, 1'b0, 2'd0, 32'hDEADBEEF, 32'h0, 8'h00};
        vecs[1] = '{1'b1, 5'd5, 32'h11223344, 4'h5, 5'd5, 5'd5, 1'b0, 2'd0, 32'hDE22BE44, 32'hDE22BE44, 8'hEF};
        vecs[2] = '{1'b0, 5'd0, 32'h0,        4'h0, 5'd5, 5'd0, 1'b0, 2'd2, 32'hDE22BE44, 32'h0, 8'h22};
        vecs[3] = '{1'b1, 5'd7, 32'hA5A5A5A5, 4'hF, 5'd7, 5'd7, 1'b0, 2'd2, 32'hA5A5A5A5, 32'hA5A5A5A5, 8'h22};
        vecs[4] = '{1'b1, 5'd0, 32'hFFFFFFFF, 4'hF, 5'd0, 5'd7, 1'b1, 2'd3, 32'h0, 32'hA5A5A5A5, 8'hA5};
        vecs[5] = '{1'b0, 5'd0, 32'h0,        4'h0, 5'd0, 5'd5, 1'b1, 2'd0, 32'h0, 32'hDE22BE44, 8'hA5};
        vecs[6] = '{1'b1, 5'd9, 32'h12345678, 4'h0, 5'd9, 5'd9, 1'b1, 2'd0, 32'h0, 32'h0, 8'h44};
        vecs[7] = '{1'b0, 5'd0, 32'h0,        4'h0, 5'd9, 5'd7, 1'b0, 2'd1, 32'h0, 32'hA5A5A5A5, 8'h00};

        // Reset state and a full read of the array
        do_reset();
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_led", 32'(led), 32'h0);
        check("rst_rd_a", rd_a, 32'h0);
        check("rst_rd_b", rd_b, 32'h0);
        for (int i = 0; i < 32; i++) begin
            ra = 5'(i);
            rb = 5'(31 - i);
            tick();
            check("rst_scan_a", rd_a, 32'h0);
            check("rst_scan_b", rd_b, 32'h0);
            check("rst_scan_led", 32'(led), 32'h0);
            check("rst_scan_busy", 32'(busy), 32'h0);
        end

        // Table-driven writes, bypass, zero reg, LED byte view
        ra = 0; rb = 0;
        tick();
        for (int i = 0; i < 8; i++) begin
            we = vecs[i].we; wa = vecs[i].wa; wd = vecs[i].wd; be = vecs[i].be;
            ra = vecs[i].ra; rb = vecs[i].rb; psel = vecs[i].psel; lsel = vecs[i].lsel;
            tick();
            check($sformatf("vec%0d_rd_a", i), rd_a, vecs[i].ea);
            check($sformatf("vec%0d_rd_b", i), rd_b, vecs[i].eb);
            check($sformatf("vec%0d_led", i), 32'(led), 32'(vecs[i].eled));
            check($sformatf("vec%0d_busy", i), 32'(busy), 32'h0);
        end
        drive_idle();

        // Soft clear: fill regs with their index, sweep, probe during sweep
        for (int i = 1; i < 32; i++) begin
            we = 1; wa = 5'(i); wd = 32'(i); be = 4'hF;
            tick();
        end
        we = 0;
        clr = 1;
        tick();
        clr = 0;
        check("clr_busy_start", 32'(busy), 32'h1);
        cyc = 0;
        while (busy && cyc < 100) begin
            we = 0; ra = 5'd31; rb = 5'd31;
            if (cyc == 5) begin
                we = 1; wa = 5'd3; wd = 32'h55; be = 4'hF; ra = 5'd3; rb = 5'd31;
            end
            if (cyc == 10) ra = 5'd10;
            tick();
            if (cyc == 5) begin
                check("clr_wr_ignored_nobypass", rd_a, 32'h0);
                check("clr_mid_rd31", rd_b, 32'd31);
            end
            if (cyc == 10) check("clr_preclear_rd10", rd_a, 32'd10);
            cyc++;
        end
        check("clr_busy_cycles", 32'(cyc), 32'd32);
        we = 0;
        for (int i = 0; i < 32; i++) begin
            ra = 5'(i);
            rb = 5'(31 - i);
            tick();
            check("clr_after_a", rd_a, 32'h0);
            check("clr_after_b", rd_b, 32'h0);
        end

        // Asynchronous reset in the middle of a sweep
        we = 1; wa = 5'd20; wd = 32'h1234; be = 4'hF;
        tick();
        we = 0; ra = 5'd20; rb = 5'd20; psel = 0; lsel = 0;
        clr = 1;
        tick();
        clr = 0;
        for (int i = 0; i < 10; i++) tick();
        check("arst_pre_rd_a", rd_a, 32'h1234);
        check("arst_pre_led", 32'(led), 32'h34);
        check("arst_pre_busy", 32'(busy), 32'h1);
        #3 rst = 1'b1;
        #1;
        check("arst_busy", 32'(busy), 32'h0);
        check("arst_led", 32'(led), 32'h0);
        check("arst_rd_a", rd_a, 32'h0);
        check("arst_rd_b", rd_b, 32'h0);
        #2 rst = 1'b0;
        we = 1; wa = 5'd6; wd = 32'hCAFE; be = 4'hF; ra = 5'd20; rb = 5'd6;
        tick();
        check("arst_reg20", rd_a, 32'h0);
        check("arst_first_write_bypass", rd_b, 32'hCAFE);
        check("arst_no_sweep", 32'(busy), 32'h0);
        we = 0; ra = 5'd6;
        tick();
        check("arst_first_write_stored", rd_a, 32'hCAFE);

        // Randomized traffic against the model
        do_reset();
        model_reset();
        for (int n = 0; n < 800; n++) begin
            we   = 1'($urandom_range(0, 1));
            wa   = 5'($urandom_range(0, 31));
            wd   = $urandom;
            be   = 4'($urandom_range(0, 15));
            ra   = ($urandom_range(0, 3) == 0) ? wa : 5'($urandom_range(0, 31));
            rb   = ($urandom_range(0, 3) == 0) ? wa : 5'($urandom_range(0, 31));
            clr  = ($urandom_range(0, 63) == 0);
            psel = 1'($urandom_range(0, 1));
            lsel = 2'($urandom_range(0, 3));
            model_cycle();
        end
        drive_idle();

        // Narrow instance: no zero register, LED byte 1, 8-cycle sweep
        s_we = 1; s_wa = 0; s_wd = 16'hBEEF; s_be = 2'b11; s_ra = 0; s_rb = 0; s_lsel = 1;
        tick();
        check("small_bypass_reg0", 32'(s_rd_a), 32'hBEEF);
        s_we = 0;
        tick();
        check("small_rd_reg0", 32'(s_rd_a), 32'hBEEF);
        check("small_led_byte1", 32'(s_led), 32'hBE);
        s_clr = 1;
        tick();
        s_clr = 0;
        cyc = 0;
        while (s_busy && cyc < 100) begin
            cyc++;
            tick();
        end
        check("small_busy_cycles", 32'(cyc), 32'd8);
        tick();
        check("small_reg0_cleared", 32'(s_rd_a), 32'h0);

        // 24-bit instance: LED select beyond the last byte reads zero
        o_we = 1; o_wa = 1; o_wd = 24'hABCDEF; o_be = 3'b111; o_ra = 1; o_lsel = 3;
        tick();
        check("odd_bypass", 32'(o_rd_a), 32'hABCDEF);
        o_we = 0;
        tick();
        check("odd_led_out_of_range", 32'(o_led), 32'h0);
        o_lsel = 2;
        tick();
        check("odd_led_byte2", 32'(o_led), 32'hAB);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
